// File: rtl/mesh_check_pkg.sv
// Shared types for the mesh write checker: expected-pattern modes and FSM states.
package mesh_check_pkg;

    typedef enum logic [1:0] {
        MODE_REV   = 2'd0,
        MODE_ID    = 2'd1,
        MODE_CONST = 2'd2,
        MODE_XOR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mesh_expect_gen.sv
// Combinational expected-word generator: the value PE k should hold after the write phase.
module mesh_expect_gen
    import mesh_check_pkg::*;
#(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  mode_e                 mode,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic [ADDR_WIDTH-1:0] k,
    output logic [DATA_WIDTH-1:0] expected
);

    logic [DATA_WIDTH-1:0] k_ext;

    assign k_ext = DATA_WIDTH'(k);

    // NOTE: assign a default first so no path through the case can infer a latch.
    always_comb begin
        expected = '0;
        case (mode)
            MODE_REV:   expected = DATA_WIDTH'(N - 1) - k_ext;
            MODE_ID:    expected = k_ext;
            MODE_CONST: expected = pattern;
            MODE_XOR:   expected = k_ext ^ pattern;
            default:    expected = '0;
        endcase
    end

endmodule

// File: rtl/mesh_write_checker.sv
// Post-write self-check for an N-PE mesh: settle, scan one PE per cycle, report result.
// Optional MESH_CHECK_MASK_EN adds err_mask_o, a per-PE mismatch bitmap.
module mesh_write_checker
    import mesh_check_pkg::*;
#(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [1:0]              mode_i,
    input  logic [DATA_WIDTH-1:0]   pattern_i,
    input  logic [CNT_WIDTH-1:0]    settle_i,
    input  logic [N*DATA_WIDTH-1:0] mem_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [ADDR_WIDTH:0]     err_count_o,
    output logic [ADDR_WIDTH-1:0]   first_err_o
`ifdef MESH_CHECK_MASK_EN
    ,
    output logic [N-1:0]            err_mask_o
`endif
);

    localparam int EW = ADDR_WIDTH + 1;

    state_e                state;
    mode_e                 mode_q;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] mem_word;
    logic [DATA_WIDTH-1:0] expected;
    logic                  mism;
    logic [EW-1:0]         err_next;

    mesh_expect_gen #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_expect (
        .mode     (mode_q),
        .pattern  (pattern_q),
        .k        (idx),
        .expected (expected)
    );

    // The mesh memory is read live; the word under test is whatever PE idx holds this cycle.
    always_comb begin
        mem_word = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(idx) == k) mem_word = mem_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign mism     = (state == SCAN) && (mem_word != expected);
    assign err_next = err_count_o + EW'(mism);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= MODE_REV;
            pattern_q   <= '0;
            cnt         <= '0;
            idx         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            err_count_o <= '0;
            first_err_o <= '0;
`ifdef MESH_CHECK_MASK_EN
            err_mask_o  <= '0;
`endif
        end else if (abort_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            err_count_o <= '0;
            first_err_o <= '0;
`ifdef MESH_CHECK_MASK_EN
            err_mask_o  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        mode_q      <= mode_e'(mode_i);
                        pattern_q   <= pattern_i;
                        cnt         <= settle_i;
                        idx         <= '0;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        err_count_o <= '0;
                        first_err_o <= '0;
`ifdef MESH_CHECK_MASK_EN
                        err_mask_o  <= '0;
`endif
                        state       <= (settle_i == '0) ? SCAN : WAIT;
                    end
                end
                WAIT: begin
                    // Leaving at a count of 1 makes SCAN start exactly settle_i cycles after start.
                    cnt <= cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) state <= SCAN;
                end
                SCAN: begin
                    err_count_o <= err_next;
                    if (mism && (err_count_o == '0)) first_err_o <= idx;
`ifdef MESH_CHECK_MASK_EN
                    err_mask_o  <= err_mask_o | (N'(mism) << idx);
`endif
                    if (int'(idx) == N - 1) begin
                        idx    <= '0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (err_next == '0);
                        state  <= DONE;
                    end else begin
                        idx <= idx + ADDR_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_write_checker.sv
// Directed self-checking bench for mesh_write_checker (N=16, 32-bit words).
module tb_mesh_write_checker;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [1:0]        mode_i = '0;
    logic [DW-1:0]     pattern_i = '0;
    logic [CW-1:0]     settle_i = '0;
    logic [N*DW-1:0]   mem_i = '0;
    logic              busy_o;
    logic              done_o;
    logic              pass_o;
    logic [AW:0]       err_count_o;
    logic [AW-1:0]     first_err_o;
`ifdef MESH_CHECK_MASK_EN
    logic [N-1:0]      err_mask_o;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    mesh_write_checker #(
        .N          (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .mode_i      (mode_i),
        .pattern_i   (pattern_i),
        .settle_i    (settle_i),
        .mem_i       (mem_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .err_count_o (err_count_o),
        .first_err_o (first_err_o)
`ifdef MESH_CHECK_MASK_EN
        ,
        .err_mask_o  (err_mask_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [DW-1:0] w);
        mem_i[k*DW +: DW] = w;
    endtask

    // Drives a one-cycle start pulse; returns at the first negedge after the accepting edge.
    task automatic pulse_start(input logic [1:0] mode, input logic [DW-1:0] pat,
                               input logic [CW-1:0] settle);
        mode_i    = mode;
        pattern_i = pat;
        settle_i  = settle;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    // Counts negedges from the start cycle until done_o; cyc must hold the current count.
    task automatic wait_done(input string tag, input int exp_lat);
        while (done_o !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 64'(cyc), 64'(exp_lat));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",  64'(busy_o), 64'h0);
        check("rst_done",  64'(done_o), 64'h0);
        check("rst_pass",  64'(pass_o), 64'h0);
        check("rst_count", 64'(err_count_o), 64'h0);
        check("rst_first", 64'(first_err_o), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: reversal pattern, settle 100 -> done at 117, pass
        for (int k = 0; k < N; k++) set_word(k, DW'(15 - k));
        pulse_start(2'd0, '0, 16'd100);
        cyc = 1;
        check("t1_busy_wait", 64'(busy_o), 64'h1);
        check("t1_pass_busy", 64'(pass_o), 64'h0);
        wait_done("t1_latency", 117);
        check("t1_pass",  64'(pass_o), 64'h1);
        check("t1_count", 64'(err_count_o), 64'h0);
        check("t1_busy_done", 64'(busy_o), 64'h0);
        repeat (3) @(negedge clk);
        check("t1_done_held", 64'(done_o), 64'h1);

        // 2: PEs 3 and 9 corrupted; re-armed from DONE
        set_word(3, '0);
        set_word(9, '0);
        pulse_start(2'd0, '0, 16'd100);
        cyc = 1;
        check("t2_rearm_done", 64'(done_o), 64'h0);
        check("t2_rearm_busy", 64'(busy_o), 64'h1);
        wait_done("t2_latency", 117);
        check("t2_pass",  64'(pass_o), 64'h0);
        check("t2_count", 64'(err_count_o), 64'h2);
        check("t2_first", 64'(first_err_o), 64'h3);
`ifdef MESH_CHECK_MASK_EN
        check("t2_mask", 64'(err_mask_o), 64'h0208);
`endif

        // 3: xor mode, settle 0 -> done at 17, pass
        for (int k = 0; k < N; k++) set_word(k, DW'(k) ^ 32'hA5A5A5A5);
        pulse_start(2'd3, 32'hA5A5A5A5, 16'd0);
        cyc = 1;
        wait_done("t3_latency", 17);
        check("t3_pass",  64'(pass_o), 64'h1);
        check("t3_count", 64'(err_count_o), 64'h0);

        // 4: extra start while scanning PE 5 is ignored
        pulse_start(2'd3, 32'hA5A5A5A5, 16'd0);
        cyc = 1;
        repeat (5) @(negedge clk);
        cyc = 6;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 7;
        wait_done("t4_latency", 17);
        check("t4_pass",  64'(pass_o), 64'h1);
        check("t4_count", 64'(err_count_o), 64'h0);

        // 5: abort during WAIT, then a fresh check
        for (int k = 0; k < N; k++) set_word(k, DW'(15 - k));
        pulse_start(2'd0, '0, 16'd50);
        repeat (9) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("t5_abort_busy", 64'(busy_o), 64'h0);
        check("t5_abort_done", 64'(done_o), 64'h0);
        repeat (60) @(negedge clk);
        check("t5_idle_done", 64'(done_o), 64'h0);
        pulse_start(2'd0, '0, 16'd3);
        cyc = 1;
        wait_done("t5_latency", 20);
        check("t5_pass", 64'(pass_o), 64'h1);

        // 6: async reset while scanning PE 8
        pulse_start(2'd0, '0, 16'd0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy_o), 64'h0);
        check("t6_rst_done", 64'(done_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(2'd0, '0, 16'd0);
        cyc = 1;
        wait_done("t6_latency", 17);
        check("t6_pass", 64'(pass_o), 64'h1);

        // 7: identity mode, only the last PE wrong
        for (int k = 0; k < N; k++) set_word(k, DW'(k));
        set_word(15, 32'h0);
        pulse_start(2'd1, '0, 16'd2);
        cyc = 1;
        wait_done("t7_latency", 19);
        check("t7_pass",  64'(pass_o), 64'h0);
        check("t7_count", 64'(err_count_o), 64'h1);
        check("t7_first", 64'(first_err_o), 64'hF);

        // 8: constant mode, every PE wrong -> count reaches N; then abort clears
        for (int k = 0; k < N; k++) set_word(k, 32'h0);
        pulse_start(2'd2, 32'h12345678, 16'd1);
        cyc = 1;
        wait_done("t8_latency", 18);
        check("t8_count", 64'(err_count_o), 64'h10);
        check("t8_first", 64'(first_err_o), 64'h0);
        check("t8_pass",  64'(pass_o), 64'h0);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("t8_abort_done",  64'(done_o), 64'h0);
        check("t8_abort_count", 64'(err_count_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
